// File: rtl/trap_ctrl_if.sv
// Core-side bundle for the trap sequencer: retirement/request inputs and
// trap-select/return outputs, with master (core) and slave (sequencer) views.
interface trap_ctrl_if #(
    parameter int A     = 16,
    parameter int DEPTH = 4
);
    localparam int DW = $clog2(DEPTH) + 1;

    logic          instr_done;
    logic [A-1:0]  pc;
    logic          irq;
    logic          swi;
    logic          fault;
    logic          rti;
    logic          sel_valid;
    logic [2:0]    trapSel;
    logic          pc_load;
    logic [A-1:0]  restore_pc;
    logic          in_trap;
    logic          ie;
    logic          irq_ack;
    logic [DW-1:0] depth;

    modport master (
        output instr_done, pc, irq, swi, fault, rti,
        input  sel_valid, trapSel, pc_load, restore_pc, in_trap, ie, irq_ack, depth
    );

    modport slave (
        input  instr_done, pc, irq, swi, fault, rti,
        output sel_valid, trapSel, pc_load, restore_pc, in_trap, ie, irq_ack, depth
    );
endinterface

// File: rtl/trap_ctrl.sv
// Trap sequencer: prioritises trap sources at instruction boundaries, keeps a
// LIFO of return PCs and restarts at 0x0000 when a trap would overflow it.
module trap_ctrl #(
    parameter int A     = 16,
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    trap_ctrl_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int DW = IW + 1;

    typedef enum logic [1:0] {RUN, ENTER, RETURN} state_t;

    state_t        state_reg, state_next;
    logic [DW-1:0] depth_reg, depth_next;
    logic          ie_reg, ie_next;
    logic          sel_valid_reg, sel_valid_next;
    logic [2:0]    trap_sel_reg, trap_sel_next;
    logic          pc_load_reg, pc_load_next;
    logic [A-1:0]  restore_pc_reg, restore_pc_next;
    logic          irq_ack_reg, irq_ack_next;
    logic          in_trap_reg;

    logic          push_en;
    logic          do_enter;
    logic          enter_irq;
    logic [2:0]    enter_code;
    logic [A-1:0]  ret_addr;
    logic [IW-1:0] push_idx;
    logic [IW-1:0] top_idx;

    logic [A-1:0]  stack_mem [DEPTH];

    assign ret_addr = bus.pc + A'(2);
    assign push_idx = depth_reg[IW-1:0];
    assign top_idx  = IW'(depth_reg - DW'(1));

    always_comb begin
        state_next      = RUN;
        depth_next      = depth_reg;
        ie_next         = ie_reg;
        sel_valid_next  = 1'b0;
        trap_sel_next   = 3'b000;
        pc_load_next    = 1'b0;
        restore_pc_next = restore_pc_reg;
        irq_ack_next    = 1'b0;
        push_en         = 1'b0;
        do_enter        = 1'b0;
        enter_irq       = 1'b0;
        enter_code      = 3'b000;

        // Retirement during ENTER/RETURN is ignored; those states fall back to RUN.
        if (state_reg == RUN && bus.instr_done) begin
            sel_valid_next = 1'b1;
            if (bus.fault || (bus.rti && depth_reg == '0)) begin
                do_enter   = 1'b1;
                enter_code = 3'b011;
            end else if (bus.swi) begin
                do_enter   = 1'b1;
                enter_code = 3'b010;
            end else if (bus.rti) begin
                restore_pc_next = stack_mem[top_idx];
                pc_load_next    = 1'b1;
                depth_next      = depth_reg - DW'(1);
                if (depth_reg == DW'(1))
                    ie_next = 1'b1;
                state_next = RETURN;
            end else if (bus.irq && ie_reg) begin
                do_enter   = 1'b1;
                enter_irq  = 1'b1;
                enter_code = 3'b001;
            end else begin
                trap_sel_next = 3'b111;
            end

            if (do_enter) begin
                state_next = ENTER;
                if (depth_reg == DW'(DEPTH)) begin
                    // Trap with a full stack: double-fault restart discards all context.
                    trap_sel_next = 3'b100;
                    depth_next    = '0;
                    ie_next       = 1'b1;
                end else begin
                    push_en       = 1'b1;
                    depth_next    = depth_reg + DW'(1);
                    ie_next       = 1'b0;
                    trap_sel_next = enter_code;
                    irq_ack_next  = enter_irq;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push_en)
            stack_mem[push_idx] <= ret_addr;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= RUN;
            depth_reg      <= '0;
            ie_reg         <= 1'b1;
            sel_valid_reg  <= 1'b0;
            trap_sel_reg   <= 3'b000;
            pc_load_reg    <= 1'b0;
            restore_pc_reg <= '0;
            irq_ack_reg    <= 1'b0;
            in_trap_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            depth_reg      <= depth_next;
            ie_reg         <= ie_next;
            sel_valid_reg  <= sel_valid_next;
            trap_sel_reg   <= trap_sel_next;
            pc_load_reg    <= pc_load_next;
            restore_pc_reg <= restore_pc_next;
            irq_ack_reg    <= irq_ack_next;
            in_trap_reg    <= (depth_next != '0);
        end
    end

    assign bus.sel_valid  = sel_valid_reg;
    assign bus.trapSel    = trap_sel_reg;
    assign bus.pc_load    = pc_load_reg;
    assign bus.restore_pc = restore_pc_reg;
    assign bus.in_trap    = in_trap_reg;
    assign bus.ie         = ie_reg;
    assign bus.irq_ack    = irq_ack_reg;
    assign bus.depth      = depth_reg;
endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
Trap sequencer for the Minx16 core. It arbitrates trap sources at instruction boundaries and produces the 3-bit trap-select code consumed by the trap address mux. It keeps a small stack of return PCs and handles return-from-trap. Trap entry escalates to a restart at 0x0000 on stack overflow.

Parameters:
A, 16, PC width in bits.
DEPTH, 4, return-PC stack entries (power of 2, 2..8).

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset
instr_done  in  1  instruction boundary strobe; all request inputs are sampled only when high
pc  in  A  PC of the instruction just completed
irq  in  1  external interrupt request, level
swi  in  1  software trap instruction completed
fault  in  1  illegal instruction / bus fault on the completed instruction
rti  in  1  return-from-trap instruction completed
sel_valid  out  1  trapSel/pc_load valid this cycle (one-cycle pulse)
trapSel  out  3  trap select code to the address mux
pc_load  out  1  load restore_pc into PC (return path)
restore_pc  out  A  return address popped from the stack
in_trap  out  1  stack not empty
ie  out  1  interrupt enable
irq_ack  out  1  one-cycle acknowledge of an accepted irq
depth  out  log2(DEPTH)+1  current stack occupancy

Behaviour:
- Reset (rst_n low at a clk edge): stack empty, depth=0, ie=1, in_trap=0, sel_valid=0, pc_load=0, irq_ack=0, trapSel=3'b000, restore_pc=0. State=RUN. Reset mid-trap discards the stack.
- Trap-select codes driven: 3'b111 = advance (pc+2), 3'b001 = irq vector 0x0400, 3'b010 = swi vector 0x0800, 3'b011 = fault vector 0x0c00, 3'b100 = restart 0x0000, 3'b000 = hold/pass PC (idle value and return cycles).
- States: RUN, ENTER, RETURN. ENTER and RETURN each last exactly one cycle, then the state goes back to RUN.
- All outputs are registered. The response appears on the cycle after instr_done (latency 1). sel_valid is high for exactly that cycle.
- In RUN with instr_done=1, events are evaluated in priority order:
  1. fault.
  2. swi.
  3. rti.
  4. irq, only when ie=1.
  5. Otherwise none: trapSel=111, sel_valid=1.
- Trap entry (fault, swi or accepted irq):
  - If depth<DEPTH: push pc+2 (mod 2^A), depth+1, ie<=0, trapSel=vector code, state ENTER.
  - irq entry also pulses irq_ack in the same cycle as sel_valid.
  - If depth==DEPTH (overflow): trapSel=100, stack cleared, depth=0, ie=1. This is a double-fault restart.
- Return (rti):
  - If depth>0: pop; restore_pc=popped value, pc_load=1, trapSel=000, sel_valid=1, state RETURN.
  - ie<=1 only when the pop leaves depth==0. Otherwise ie stays 0.
  - rti with depth==0 is treated as fault (trapSel=011, push pc+2).
- Simultaneous requests: only the highest-priority event is acted on. Lower ones are dropped, except irq, which is level-held and re-evaluated at the next boundary. fault+rti: fault wins and no pop occurs.
- instr_done asserted in ENTER or RETURN is ignored (the core must not retire during those cycles). Requests are ignored whenever instr_done=0.
- Stack is LIFO, addressed by depth. Wrap-around of pc+2 from 16'hFFFE gives 16'h0000.
- in_trap = (depth!=0), registered alongside depth.

Test Plan:
- Reset, then instr_done with pc=16'h0100 and no requests -> next cycle sel_valid=1, trapSel=111, depth=0, ie=1.
- irq=1 at pc=16'h0200 -> trapSel=001, irq_ack=1, depth=1, ie=0. A second irq at the next boundary -> trapSel=111 (masked). Then rti -> pc_load=1, restore_pc=16'h0202, ie=1, depth=0.
- fault+swi+irq together at pc=16'h0300 -> trapSel=011 only, stack top 16'h0302. irq is still pending after rti -> next boundary trapSel=001.
- DEPTH=4: five nested swi at pc=16'h0010,0020,0030,0040,0050 -> first four give trapSel=010 with depth 1..4. The fifth gives trapSel=100, depth=0, ie=1.
- Nested pops: after pushes of 16'h0A02 then 16'h0B02, two rti give restore_pc=16'h0B02 (ie stays 0), then 16'h0A02 (ie=1). A third rti gives trapSel=011.
- swi at pc=16'hFFFE -> pushed value 16'h0000. rst_n low while depth=2 -> depth=0, ie=1, trapSel=000, sel_valid=0 on the following cycle.
